// File: rtl/wb_write_dispatch.sv
// Write-back dispatch: buffers register-file writes in a small FIFO and issues one per cycle.
// Optional WB_WRITE_DISPATCH_BYPASS_EN sends a request straight to the wr_* registers when the FIFO is empty.
module wb_write_dispatch #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 3,
    parameter int DEPTH      = 4
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         req_valid_i,
    input  logic [ADDR_WIDTH-1:0]        req_addr_i,
    input  logic [DATA_WIDTH-1:0]        req_data_i,
    output logic                         req_ready_o,
    input  logic                         hold_i,
    input  logic                         flush_i,
    output logic                         wr_en_o,
    output logic [ADDR_WIDTH-1:0]        wr_addr_o,
    output logic [DATA_WIDTH-1:0]        wr_data_o,
    output logic [$clog2(DEPTH):0]       count_o,
    output logic                         empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    // Handshake: a request transfers on a rising edge where req_valid_i && req_ready_o
    // (and no flush); the producer must hold its request until that edge.
    logic [EW-1:0]  r_mem [DEPTH];
    logic [PW-1:0]  r_rd_ptr;
    logic [PW-1:0]  r_wr_ptr;
    logic [CW-1:0]  r_count;
    logic           r_wr_en;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [DATA_WIDTH-1:0] r_wr_data;

    logic w_push;
    logic w_pop;
    logic w_bypass;
    logic w_push_fifo;
    logic [EW-1:0] w_head;

    assign req_ready_o = !rst_i && (r_count < CW'(DEPTH));
    assign w_push      = req_valid_i && req_ready_o && !flush_i;
    assign w_pop       = !hold_i && !flush_i && (r_count != '0);
`ifdef WB_WRITE_DISPATCH_BYPASS_EN
    assign w_bypass    = w_push && (r_count == '0) && !hold_i;
`else
    assign w_bypass    = 1'b0;
`endif
    assign w_push_fifo = w_push && !w_bypass;
    assign w_head      = r_mem[r_rd_ptr];

    // Storage is not reset; occupancy is tracked solely by the pointers and count.
    always_ff @(posedge clk_i) begin
        if (w_push_fifo) begin
            r_mem[r_wr_ptr] <= {req_addr_i, req_data_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= '0;
            r_wr_data <= '0;
        end else if (flush_i) begin
            r_count  <= '0;
            r_rd_ptr <= r_wr_ptr;
            r_wr_en  <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            if (w_pop) begin
                r_wr_addr <= w_head[EW-1:DATA_WIDTH];
                r_wr_data <= w_head[DATA_WIDTH-1:0];
                r_wr_en   <= 1'b1;
                r_rd_ptr  <= r_rd_ptr + PW'(1);
            end else if (w_bypass) begin
                r_wr_addr <= req_addr_i;
                r_wr_data <= req_data_i;
                r_wr_en   <= 1'b1;
            end
            if (w_push_fifo) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_push_fifo && !w_pop) begin
                r_count <= r_count + CW'(1);
            end else if (!w_push_fifo && w_pop) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    assign wr_en_o   = r_wr_en;
    assign wr_addr_o = r_wr_addr;
    assign wr_data_o = r_wr_data;
    assign count_o   = r_count;
    assign empty_o   = (r_count == '0);
endmodule

// File: tb/tb_wb_write_dispatch.sv
// Self-checking bench for wb_write_dispatch: reference queue model checked every cycle plus directed checks.
module tb_wb_write_dispatch;
  localparam int DW = 32;
  localparam int AW = 3;
  localparam int DEPTH = 4;
  localparam int W = AW + DW;
`ifdef WB_WRITE_DISPATCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_i = 1'b1;
  logic req_valid_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_data_i = '0;
  logic req_ready_o;
  logic hold_i = 1'b0;
  logic flush_i = 1'b0;
  logic wr_en_o;
  logic [AW-1:0] wr_addr_o;
  logic [DW-1:0] wr_data_o;
  logic [$clog2(DEPTH):0] count_o;
  logic empty_o;

  int n_checks = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  wb_write_dispatch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_addr_i(req_addr_i),
    .req_data_i(req_data_i), .req_ready_o(req_ready_o), .hold_i(hold_i), .flush_i(flush_i),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .wr_data_o(wr_data_o),
    .count_o(count_o), .empty_o(empty_o)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // scoreboard: accepted requests wait in exp_q until the model issues them
  logic [W-1:0] exp_q[$];
  logic m_en = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;
  bit mon_on = 1'b0;

  always @(posedge clk) begin
    bit acc;
    logic [W-1:0] e;
    acc = !rst_i && req_valid_i && !flush_i && (exp_q.size() < DEPTH);
    if (rst_i) begin
      exp_q.delete();
      m_en = 1'b0; m_addr = '0; m_data = '0;
      mon_on = 1'b1;
    end else if (flush_i) begin
      exp_q.delete();
      m_en = 1'b0;
    end else begin
      m_en = 1'b0;
      if (!hold_i && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        m_addr = e[W-1:DW]; m_data = e[DW-1:0]; m_en = 1'b1;
      end else if (BYPASS && !hold_i && acc) begin
        m_addr = req_addr_i; m_data = req_data_i; m_en = 1'b1;
        acc = 1'b0;
      end
      if (acc) exp_q.push_back({req_addr_i, req_data_i});
    end
  end

  always @(negedge clk) begin
    if (mon_on) begin
      check("wr_en", wr_en_o, m_en);
      check("wr_addr", wr_addr_o, m_addr);
      check("wr_data", wr_data_o, m_data);
      check("count", count_o, exp_q.size());
      check("empty", empty_o, exp_q.size() == 0);
      check("ready", req_ready_o, !rst_i && (exp_q.size() < DEPTH));
    end
  end

  // driver: set inputs for the next edge, return #1 after it
  task automatic step(input bit v, input int a, input int d, input bit h, input bit f, input bit r);
    req_valid_i = v; req_addr_i = AW'(a); req_data_i = DW'(d);
    hold_i = h; flush_i = f; rst_i = r;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // reset with a request pending
    step(1, 2, 32'h1111, 0, 0, 1);
    step(1, 2, 32'h1111, 0, 0, 1);
    check("rst_ready", req_ready_o, 0);
    check("rst_wr_en", wr_en_o, 0);
    check("rst_count", count_o, 0);
    step(0, 0, 0, 0, 0, 0);
    check("post_rst_ready", req_ready_o, 1);
    check("post_rst_empty", empty_o, 1);

    // single write latency
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    check("single_n", wr_en_o, BYPASS);
    step(0, 0, 0, 0, 0, 0);
    check("single_n1", wr_en_o, !BYPASS);
    check("single_addr", wr_addr_o, 5);
    check("single_data", wr_data_o, 32'hDEADBEEF);
    idle(2);
    check("single_after", wr_en_o, 0);

    // fill under hold, then release with a retry pending
    for (int i = 0; i < 4; i++) step(1, i, 32'hA0 + i, 1, 0, 0);
    check("fill_count", count_o, 4);
    check("fill_ready", req_ready_o, 0);
    step(1, 4, 32'hA4, 1, 0, 0);
    check("fill_hold_count", count_o, 4);
    for (int i = 0; i < 3; i++) step(1, 4, 32'hA4, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    idle(3);
    check("fill_drain", count_o, 0);

    // back-to-back with wrap
    for (int i = 0; i < 10; i++) begin
      step(1, i % 8, i, 0, 0, 0);
      check("b2b_count_le1", count_o <= 1, 1);
    end
    idle(3);

    // flush with a request in the flush cycle
    for (int i = 0; i < 3; i++) step(1, i + 1, 32'hF0 + i, 1, 0, 0);
    check("flush_pre_count", count_o, 3);
    step(1, 7, 32'hF7, 1, 1, 0);
    check("flush_count", count_o, 0);
    check("flush_wr_en", wr_en_o, 0);
    idle(3);

    // reset mid-operation
    for (int i = 0; i < 4; i++) step(1, 6 - i, 32'hC0 + i, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("midrst_pre_en", wr_en_o, 1);
    check("midrst_pre_count", count_o, 3);
    step(0, 0, 0, 0, 0, 1);
    check("midrst_en", wr_en_o, 0);
    check("midrst_count", count_o, 0);
    check("midrst_addr", wr_addr_o, 0);
    check("midrst_data", wr_data_o, 0);
    idle(4);
    check("midrst_quiet", wr_en_o, 0);

    // random traffic
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom,
           $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, 0);
    idle(8);
    check("final_drain", count_o, 0);
    check("final_q", exp_q.size(), 0);

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
